// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_pkg
//  Brief    : Shared types and constants for the CPU-to-memory bridge.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    // Bridge transaction state
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SRAM_ACC = 2'd1,
        ST_PER_ACC  = 2'd2,
        ST_UNMAP    = 2'd3
    } state_t;

    // Decoded destination of a request
    typedef enum logic [1:0] {
        TGT_SRAM   = 2'd0,
        TGT_PERIPH = 2'd1,
        TGT_NONE   = 2'd2
    } target_t;

    // Data returned to the core for reads that never reach a real target
    localparam logic [31:0] UNMAP_RDATA   = 32'h0000_0000;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

    // Width of the shared latency / timeout counter
    localparam int CNT_W = 16;

endpackage : mem_bus_pkg
`default_nettype wire

// File: rtl/mem_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mem_addr_decode
//  Brief    : Maps a byte address to SRAM, peripheral or unmapped space and
//             produces the region-relative word offset.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_addr_decode
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE   = 32'h0000_4000,
    parameter int          SRAM_AW     = 12,
    parameter logic [31:0] PERIPH_BASE = 32'h0001_0000,
    parameter int          PERIPH_AW   = 8
) (
    input  logic [31:0]          i_address,
    output logic [1:0]           o_target,
    output logic [SRAM_AW-1:0]   o_sram_offset,
    output logic [PERIPH_AW-1:0] o_per_offset
);

    logic [31:0] w_sram_rel;
    logic [31:0] w_per_rel;
    logic        w_sram_hit;
    logic        w_per_hit;
    logic        w_unused_byte_bits;

    // Subtracting the base wraps addresses below it to huge values, so a single
    // "upper bits are zero" test covers both ends of the window.
    assign w_sram_rel = i_address - SRAM_BASE;
    assign w_per_rel  = i_address - PERIPH_BASE;
    assign w_sram_hit = (w_sram_rel[31:SRAM_AW+2] == '0);
    assign w_per_hit  = (w_per_rel[31:PERIPH_AW+2] == '0);

    assign o_sram_offset = w_sram_rel[SRAM_AW+1:2];
    assign o_per_offset  = w_per_rel[PERIPH_AW+1:2];

    // Byte-lane bits are ignored; accesses are always whole words
    assign w_unused_byte_bits = ^{w_sram_rel[1:0], w_per_rel[1:0]};

    // Select the target, SRAM taking precedence should the windows overlap
    always_comb begin
        o_target = TGT_NONE;
        if (w_sram_hit) begin
            o_target = TGT_SRAM;
        end else if (w_per_hit) begin
            o_target = TGT_PERIPH;
        end
    end

endmodule : mem_addr_decode
`default_nettype wire

// File: rtl/cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mem_bridge
//  Brief    : Turns the core's single-cycle re/we pulses into SRAM or
//             valid/ready peripheral accesses, with peripheral timeout and a
//             sticky bus-error flag that records the first failing address.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_bridge
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE   = 32'h0000_4000,
    parameter int          SRAM_AW     = 12,
    parameter int          SRAM_LAT    = 1,
    parameter logic [31:0] PERIPH_BASE = 32'h0001_0000,
    parameter int          PERIPH_AW   = 8,
    parameter int          TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          cpu_address,
    input  logic [31:0]          cpu_write_data,
    input  logic                 cpu_re,
    input  logic                 cpu_we,
    output logic [31:0]          cpu_read_data,
    output logic                 cpu_mem_busy,
    output logic                 sram_en,
    output logic                 sram_we,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic [31:0]          sram_wdata,
    input  logic [31:0]          sram_rdata,
    output logic                 per_valid,
    output logic                 per_we,
    output logic [PERIPH_AW-1:0] per_addr,
    output logic [31:0]          per_wdata,
    input  logic [31:0]          per_rdata,
    input  logic                 per_ready,
    output logic                 bus_err,
    output logic [31:0]          bus_err_addr
);

    localparam logic [CNT_W-1:0] c_sram_lat     = 16'(SRAM_LAT);
    localparam logic [CNT_W-1:0] c_timeout_last = 16'(TIMEOUT - 1);

    state_t                 state_q,    state_d;
    logic [31:0]            addr_q,     addr_d;
    logic [31:0]            wdata_q,    wdata_d;
    logic                   we_q,       we_d;
    logic [SRAM_AW-1:0]     sram_off_q, sram_off_d;
    logic [PERIPH_AW-1:0]   per_off_q,  per_off_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;
    logic [31:0]            rdata_q,    rdata_d;
    logic                   busy_q,     busy_d;
    logic                   err_q,      err_d;
    logic [31:0]            err_addr_q, err_addr_d;

    logic                   w_req;
    logic                   w_done;
    logic                   w_err_hit;
    logic [31:0]            w_err_src;
    logic [1:0]             w_target;
    logic [SRAM_AW-1:0]     w_sram_off;
    logic [PERIPH_AW-1:0]   w_per_off;

    assign w_req = cpu_re | cpu_we;

    mem_addr_decode #(
        .SRAM_BASE   (SRAM_BASE),
        .SRAM_AW     (SRAM_AW),
        .PERIPH_BASE (PERIPH_BASE),
        .PERIPH_AW   (PERIPH_AW)
    ) u_decode (
        .i_address     (cpu_address),
        .o_target      (w_target),
        .o_sram_offset (w_sram_off),
        .o_per_offset  (w_per_off)
    );

    // Next-state, completion and sticky-error logic for the single outstanding request
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        sram_off_d = sram_off_q;
        per_off_d  = per_off_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        w_done     = 1'b0;
        w_err_hit  = 1'b0;
        w_err_src  = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    addr_d     = cpu_address;
                    wdata_d    = cpu_write_data;
                    we_d       = cpu_we;          // re+we together resolves to a write
                    sram_off_d = w_sram_off;
                    per_off_d  = w_per_off;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    case (w_target)
                        TGT_SRAM:   state_d = ST_SRAM_ACC;
                        TGT_PERIPH: state_d = ST_PER_ACC;
                        default:    state_d = ST_UNMAP;
                    endcase
                    if (cpu_re && cpu_we) begin
                        w_err_hit = 1'b1;
                        w_err_src = cpu_address;
                    end
                end
            end
            ST_SRAM_ACC: begin
                cnt_d = cnt_q + 16'd1;
                if (we_q) begin
                    w_done = 1'b1;
                end else if (cnt_q == c_sram_lat) begin
                    rdata_d = sram_rdata;
                    w_done  = 1'b1;
                end
            end
            ST_PER_ACC: begin
                cnt_d = cnt_q + 16'd1;
                if (per_ready) begin
                    if (!we_q) begin
                        rdata_d = per_rdata;
                    end
                    w_done = 1'b1;
                end else if (cnt_q == c_timeout_last) begin
                    if (!we_q) begin
                        rdata_d = TIMEOUT_RDATA;
                    end
                    w_err_hit = 1'b1;
                    w_done    = 1'b1;
                end
            end
            ST_UNMAP: begin
                if (!we_q) begin
                    rdata_d = UNMAP_RDATA;
                end
                w_err_hit = 1'b1;
                w_done    = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_done) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end

        // A pulse arriving while busy is dropped; an in-flight error wins the address slot
        if (w_req && (state_q != ST_IDLE) && !w_err_hit) begin
            w_err_hit = 1'b1;
            w_err_src = cpu_address;
        end

        if (w_err_hit && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = w_err_src;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            sram_off_q <= '0;
            per_off_q  <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            sram_off_q <= sram_off_d;
            per_off_q  <= per_off_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // SRAM strobe lives only in the first access cycle
    assign sram_en    = (state_q == ST_SRAM_ACC) && (cnt_q == '0);
    assign sram_we    = sram_en && we_q;
    assign sram_addr  = sram_off_q;
    assign sram_wdata = wdata_q;

    // Peripheral request held for the whole PER_ACC residency
    assign per_valid  = (state_q == ST_PER_ACC);
    assign per_we     = per_valid && we_q;
    assign per_addr   = per_off_q;
    assign per_wdata  = wdata_q;

    assign cpu_read_data = rdata_q;
    assign cpu_mem_busy  = busy_q;
    assign bus_err       = err_q;
    assign bus_err_addr  = err_addr_q;

endmodule : cpu_mem_bridge
`default_nettype wire

// File: tb/tb_cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_mem_bridge
//  Brief    : Scoreboard bench for cpu_mem_bridge with SRAM and peripheral
//             behavioural models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_bridge;

    localparam int SRAM_AW   = 12;
    localparam int PERIPH_AW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [31:0]          cpu_address = '0;
    logic [31:0]          cpu_write_data = '0;
    logic                 cpu_re = 1'b0;
    logic                 cpu_we = 1'b0;
    logic [31:0]          cpu_read_data;
    logic                 cpu_mem_busy;
    logic                 sram_en;
    logic                 sram_we;
    logic [SRAM_AW-1:0]   sram_addr;
    logic [31:0]          sram_wdata;
    logic [31:0]          sram_rdata = '0;
    logic                 per_valid;
    logic                 per_we;
    logic [PERIPH_AW-1:0] per_addr;
    logic [31:0]          per_wdata;
    logic [31:0]          per_rdata = '0;
    logic                 per_ready = 1'b0;
    logic                 bus_err;
    logic [31:0]          bus_err_addr;

    cpu_mem_bridge #(
        .SRAM_BASE   (32'h0000_4000),
        .SRAM_AW     (SRAM_AW),
        .SRAM_LAT    (1),
        .PERIPH_BASE (32'h0001_0000),
        .PERIPH_AW   (PERIPH_AW),
        .TIMEOUT     (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .cpu_re         (cpu_re),
        .cpu_we         (cpu_we),
        .cpu_read_data  (cpu_read_data),
        .cpu_mem_busy   (cpu_mem_busy),
        .sram_en        (sram_en),
        .sram_we        (sram_we),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata),
        .per_valid      (per_valid),
        .per_we         (per_we),
        .per_addr       (per_addr),
        .per_wdata      (per_wdata),
        .per_rdata      (per_rdata),
        .per_ready      (per_ready),
        .bus_err        (bus_err),
        .bus_err_addr   (bus_err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string              name;
        int                 busy_len;
        logic [31:0]        rdata;
        logic               err;
        logic [31:0]        err_addr;
        int                 n_en;
        logic [SRAM_AW-1:0] sram_addr;
        logic               sram_we;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // SRAM model: data appears one cycle after the strobe, garbage otherwise
    logic [31:0] mem [0:(1<<SRAM_AW)-1];
    logic        sram_pend = 1'b0;
    logic [31:0] sram_pend_data = '0;
    always @(negedge clk) begin
        sram_rdata = sram_pend ? sram_pend_data : 32'hBAD0_BAD0;
        sram_pend  = 1'b0;
        if (sram_en) begin
            if (sram_we) begin
                mem[sram_addr] = sram_wdata;
            end else begin
                sram_pend      = 1'b1;
                sram_pend_data = mem[sram_addr];
            end
        end
    end

    // Peripheral model: ready in the per_delay-th cycle of per_valid (0 = never)
    int                   per_delay = 0;
    int                   per_cnt = 0;
    logic [PERIPH_AW-1:0] exp_per_addr = '0;
    logic                 exp_per_we = 1'b0;
    logic [31:0]          exp_per_wdata = '0;
    always @(negedge clk) begin
        if (rst || !per_valid) begin
            per_cnt   = 0;
            per_ready = 1'b0;
        end else begin
            per_cnt++;
            per_ready = (per_delay != 0) && (per_cnt == per_delay);
            if (per_ready) begin
                chk("per_addr", 32'(per_addr), 32'(exp_per_addr));
                chk("per_we", 32'(per_we), 32'(exp_per_we));
                if (exp_per_we) chk("per_wdata", per_wdata, exp_per_wdata);
            end
        end
    end

    // Monitor: measures each busy window and compares against the scoreboard
    logic               mon_in_tx = 1'b0;
    int                 mon_len = 0;
    int                 mon_nen = 0;
    logic [SRAM_AW-1:0] mon_sa = '0;
    logic               mon_swe = 1'b0;
    exp_t               mon_e;
    always @(negedge clk) begin
        if (rst) begin
            mon_in_tx = 1'b0;
        end else if (cpu_mem_busy) begin
            if (!mon_in_tx) begin
                mon_in_tx = 1'b1;
                mon_len   = 0;
                mon_nen   = 0;
                mon_sa    = '0;
                mon_swe   = 1'b0;
            end
            mon_len++;
            if (sram_en) begin
                mon_nen++;
                mon_sa  = sram_addr;
                mon_swe = sram_we;
            end
        end else if (mon_in_tx) begin
            mon_in_tx = 1'b0;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_completion: got a completion, expected none");
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, ".busy_len"}, 32'(mon_len), 32'(mon_e.busy_len));
                chk({mon_e.name, ".rdata"}, cpu_read_data, mon_e.rdata);
                chk({mon_e.name, ".bus_err"}, 32'(bus_err), 32'(mon_e.err));
                chk({mon_e.name, ".bus_err_addr"}, bus_err_addr, mon_e.err_addr);
                chk({mon_e.name, ".n_sram_en"}, 32'(mon_nen), 32'(mon_e.n_en));
                if (mon_e.n_en == 1) begin
                    chk({mon_e.name, ".sram_addr"}, 32'(mon_sa), 32'(mon_e.sram_addr));
                    chk({mon_e.name, ".sram_we"}, 32'(mon_swe), 32'(mon_e.sram_we));
                end
            end
        end
    end

    task automatic push(input string nm, input int bl, input logic [31:0] rd,
                        input logic er, input logic [31:0] ea, input int nen,
                        input logic [SRAM_AW-1:0] sa, input logic swe);
        exp_t e;
        e.name = nm; e.busy_len = bl; e.rdata = rd; e.err = er; e.err_addr = ea;
        e.n_en = nen; e.sram_addr = sa; e.sram_we = swe;
        sb.push_back(e);
    endtask

    task automatic issue(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cpu_re = re; cpu_we = we; cpu_address = a; cpu_write_data = d;
        @(posedge clk);
        #1;
        cpu_re = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!cpu_mem_busy) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s.idle_wait: busy still high after 100 cycles, expected idle", nm);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem[4] = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset.rdata", cpu_read_data, 32'h0);
        chk("reset.busy", 32'(cpu_mem_busy), 32'h0);
        chk("reset.bus_err", 32'(bus_err), 32'h0);
        chk("reset.bus_err_addr", bus_err_addr, 32'h0);
        chk("reset.sram_en", 32'(sram_en), 32'h0);
        chk("reset.per_valid", 32'(per_valid), 32'h0);

        // SRAM read, then hold check
        push("sram_rd", 2, 32'h1234_5678, 1'b0, 32'h0, 1, 12'd4, 1'b0);
        issue(1'b1, 1'b0, 32'h0000_4010, 32'h0);
        wait_idle("sram_rd");
        repeat (10) @(negedge clk);
        chk("sram_rd.hold", cpu_read_data, 32'h1234_5678);

        // Unaligned SRAM write; read data must not move
        push("sram_wr", 1, 32'h1234_5678, 1'b0, 32'h0, 1, 12'd8, 1'b1);
        issue(1'b0, 1'b1, 32'h0000_4022, 32'hCAFE_BABE);
        wait_idle("sram_wr");
        push("sram_rdback", 2, 32'hCAFE_BABE, 1'b0, 32'h0, 1, 12'd8, 1'b0);
        issue(1'b1, 1'b0, 32'h0000_4020, 32'h0);
        wait_idle("sram_rdback");

        // Peripheral read, ready in the 5th cycle
        per_delay = 5; per_rdata = 32'h0000_00A5; exp_per_addr = 8'd1; exp_per_we = 1'b0;
        push("per_rd", 5, 32'h0000_00A5, 1'b0, 32'h0, 0, '0, 1'b0);
        issue(1'b1, 1'b0, 32'h0001_0004, 32'h0);
        wait_idle("per_rd");

        // Peripheral write, ready in the first cycle
        per_delay = 1; exp_per_addr = 8'd2; exp_per_we = 1'b1; exp_per_wdata = 32'h1122_3344;
        push("per_wr", 1, 32'h0000_00A5, 1'b0, 32'h0, 0, '0, 1'b0);
        issue(1'b0, 1'b1, 32'h0001_0008, 32'h1122_3344);
        wait_idle("per_wr");

        // Peripheral timeout
        per_delay = 0;
        push("per_tmo", 16, 32'hFFFF_FFFF, 1'b1, 32'h0001_0000, 0, '0, 1'b0);
        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0);
        wait_idle("per_tmo");

        // Reset in the middle of a peripheral access
        issue(1'b1, 1'b0, 32'h0001_0004, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.per_valid", 32'(per_valid), 32'h0);
        chk("midrst.busy", 32'(cpu_mem_busy), 32'h0);
        chk("midrst.bus_err", 32'(bus_err), 32'h0);
        chk("midrst.bus_err_addr", bus_err_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push("after_rst_rd", 2, 32'h1234_5678, 1'b0, 32'h0, 1, 12'd4, 1'b0);
        issue(1'b1, 1'b0, 32'h0000_4010, 32'h0);
        wait_idle("after_rst_rd");

        // Unmapped accesses: first error address sticks
        push("unmap1", 1, 32'h0, 1'b1, 32'h8000_0000, 0, '0, 1'b0);
        issue(1'b1, 1'b0, 32'h8000_0000, 32'h0);
        wait_idle("unmap1");
        push("unmap2", 1, 32'h0, 1'b1, 32'h8000_0000, 0, '0, 1'b0);
        issue(1'b1, 1'b0, 32'h9000_0000, 32'h0);
        wait_idle("unmap2");

        // re and we together: performed as a write, flagged as an error
        do_reset();
        push("re_we", 1, 32'h0, 1'b1, 32'h0000_4030, 1, 12'd12, 1'b1);
        issue(1'b1, 1'b1, 32'h0000_4030, 32'h55AA_55AA);
        wait_idle("re_we");
        push("re_we_rdback", 2, 32'h55AA_55AA, 1'b1, 32'h0000_4030, 1, 12'd12, 1'b0);
        issue(1'b1, 1'b0, 32'h0000_4030, 32'h0);
        wait_idle("re_we_rdback");

        // Pulse while busy is ignored but recorded as an error
        do_reset();
        push("busy_pulse", 2, 32'h1234_5678, 1'b1, 32'h0000_4020, 1, 12'd4, 1'b0);
        issue(1'b1, 1'b0, 32'h0000_4010, 32'h0);
        @(negedge clk);
        cpu_re = 1'b1; cpu_address = 32'h0000_4020;
        @(posedge clk);
        #1;
        cpu_re = 1'b0;
        wait_idle("busy_pulse");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cpu_mem_bridge
`default_nettype wire
